// File: rtl/pc_pkg.sv
// Shared redirect-source encoding and priority compare for the PC unit.
package pc_pkg;

    // Numeric order is the priority order; SrcNone always loses.
    typedef enum logic [2:0] {
        SrcNone   = 3'd0,
        SrcRet    = 3'd1,
        SrcJump   = 3'd2,
        SrcBranch = 3'd3,
        SrcExc    = 3'd4
    } redir_src_e;

    // A candidate wins against a held redirect when it is of equal or higher priority.
    function automatic logic src_outranks(input redir_src_e cand, input redir_src_e held);
        return (cand != SrcNone) && (cand >= held);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] mem_d [RAS_DEPTH];
    logic [PtrW-1:0]  sp_q, sp_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  top_idx;
    logic             do_pop;

    // sp_q is the next free slot; wrapping it is what discards the oldest entry.
    assign top_idx = sp_q - PtrW'(1);
    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(RAS_DEPTH));
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push_i && do_pop) begin
            mem_d[top_idx] = push_data_i;
        end else if (push_i) begin
            mem_d[sp_q] = push_data_i;
            sp_d        = sp_q + PtrW'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (do_pop) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised redirects, stall-time redirect capture and an
// optional return-address stack (enabled by defining PC_UNIT_RAS_EN).
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h0000_0080,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             ExcEn,
    input  logic             BranchEn,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             JumpEn,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             CallEn,
    input  logic             RetEn,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlusInc,
    output logic             RedirectPending,
    output logic             RasEmpty
);

    localparam logic [WIDTH-1:0] AlignMask = ~(WIDTH'(INC) - WIDTH'(1));

    logic [WIDTH-1:0] pc_q, pc_d;
    redir_src_e       pend_src_q, pend_src_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    redir_src_e       new_src;
    logic [WIDTH-1:0] new_tgt;
    logic             take_new;
    logic [WIDTH-1:0] pc_plus_inc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_ret;

    assign pc_plus_inc = pc_q + WIDTH'(INC);

`ifdef PC_UNIT_RAS_EN
    logic unused_ras_full;

    assign ras_ret = RetEn && !ras_empty;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (Clk),
        .rst_ni      (Reset),
        .push_i      (CallEn && !Stall),
        .pop_i       (RetEn && !Stall),
        .push_data_i (pc_plus_inc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (unused_ras_full)
    );
`else
    logic unused_ras;

    assign unused_ras = ^{CallEn, RetEn};
    assign ras_ret    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
`endif

    always_comb begin
        new_src = SrcNone;
        new_tgt = '0;
        if (ExcEn) begin
            new_src = SrcExc;
            new_tgt = EXC_VECTOR;
        end else if (BranchEn) begin
            new_src = SrcBranch;
            new_tgt = BranchTarget;
        end else if (JumpEn) begin
            new_src = SrcJump;
            new_tgt = JumpTarget;
        end
        new_tgt  = new_tgt & AlignMask;
        take_new = src_outranks(new_src, pend_src_q);

        pc_d       = pc_q;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        if (Stall) begin
            if (take_new) begin
                pend_src_d = new_src;
                pend_tgt_d = new_tgt;
            end
        end else begin
            pend_src_d = SrcNone;
            pend_tgt_d = '0;
            if (take_new) begin
                pc_d = new_tgt;
            end else if (pend_src_q != SrcNone) begin
                pc_d = pend_tgt_q;
            end else if (ras_ret) begin
                pc_d = ras_top;
            end else begin
                pc_d = pc_plus_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q       <= RESET_VECTOR;
            pend_src_q <= SrcNone;
            pend_tgt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign PCResult        = pc_q;
    assign PCPlusInc       = pc_plus_inc;
    assign RedirectPending = (pend_src_q != SrcNone);
    assign RasEmpty        = ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: behavioural model compared every cycle plus
// directed literal checks; RAS scenarios run only when PC_UNIT_RAS_EN is defined.
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit RasEn = 1'b1;
`else
    localparam bit RasEn = 1'b0;
`endif
    localparam int RasDepth = 4;

    logic        Clk = 1'b0;
    logic        Reset, Stall, ExcEn, BranchEn, JumpEn, CallEn, RetEn;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] PCResult, PCPlusInc;
    logic        RedirectPending, RasEmpty;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    bit          m_pv;
    int          m_pr;
    logic [31:0] m_pt;
    logic [31:0] m_ras[$];

    pc_unit u_dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Stall           (Stall),
        .ExcEn           (ExcEn),
        .BranchEn        (BranchEn),
        .BranchTarget    (BranchTarget),
        .JumpEn          (JumpEn),
        .JumpTarget      (JumpTarget),
        .CallEn          (CallEn),
        .RetEn           (RetEn),
        .PCResult        (PCResult),
        .PCPlusInc       (PCPlusInc),
        .RedirectPending (RedirectPending),
        .RasEmpty        (RasEmpty)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: priority rank 3=exc, 2=branch, 1=jump; pending wins unless outranked or tied.
    initial begin
        forever begin
            int          nr;
            logic [31:0] nt;
            logic [31:0] nxt;
            bit          ret_ok;
            @(posedge Clk or negedge Reset);
            nr = 0;
            nt = 32'h0;
            if (ExcEn) begin nr = 3; nt = 32'h80; end
            else if (BranchEn) begin nr = 2; nt = BranchTarget; end
            else if (JumpEn) begin nr = 1; nt = JumpTarget; end
            nt = nt & 32'hFFFF_FFFC;
            if (!Reset) begin
                m_pc = 32'h0;
                m_pv = 0;
                m_pr = 0;
                m_pt = 32'h0;
                m_ras.delete();
            end else if (!Stall) begin
                ret_ok = RasEn && RetEn && (m_ras.size() != 0);
                if (nr != 0 && nr >= m_pr) nxt = nt;
                else if (m_pv) nxt = m_pt;
                else if (ret_ok) nxt = m_ras[$];
                else nxt = m_pc + 32'd4;
                if (RasEn) begin
                    if (ret_ok) void'(m_ras.pop_back());
                    if (CallEn) begin
                        m_ras.push_back(m_pc + 32'd4);
                        if (m_ras.size() > RasDepth) void'(m_ras.pop_front());
                    end
                end
                m_pc = nxt;
                m_pv = 0;
                m_pr = 0;
                m_pt = 32'h0;
            end else if (nr != 0 && nr >= m_pr) begin
                m_pv = 1;
                m_pr = nr;
                m_pt = nt;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        forever begin
            @(negedge Clk);
            chk("model_pc", PCResult, m_pc);
            chk("model_pcplusinc", PCPlusInc, m_pc + 32'd4);
            chk("model_pending", {31'h0, RedirectPending}, {31'h0, m_pv});
            chk("model_rasempty", {31'h0, RasEmpty}, {31'h0, (m_ras.size() == 0)});
        end
    end

    task automatic set_in(input bit st, input bit ex, input bit be, input logic [31:0] bt,
                          input bit je, input logic [31:0] jt, input bit ce, input bit re);
        Stall        = st;
        ExcEn        = ex;
        BranchEn     = be;
        BranchTarget = bt;
        JumpEn       = je;
        JumpTarget   = jt;
        CallEn       = ce;
        RetEn        = re;
    endtask

    task automatic drive(input bit st, input bit ex, input bit be, input logic [31:0] bt,
                         input bit je, input logic [31:0] jt, input bit ce, input bit re);
        set_in(st, ex, be, bt, je, jt, ce, re);
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0;
        set_in(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge Clk);
        chk("reset_pc", PCResult, 32'h0);
        chk("reset_pending", {31'h0, RedirectPending}, 32'h0);
        chk("reset_rasempty", {31'h0, RasEmpty}, 32'h1);
        #2 Reset = 1'b1;
        @(negedge Clk);
        chk("first_inc", PCResult, 32'h4);

        // Wrap modulo 2^32
        drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_pre", PCResult, 32'hFFFF_FFFC);
        chk("wrap_plusinc", PCPlusInc, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("wrap_post", PCResult, 32'h0);

        // Same-cycle priority and target alignment
        drive(0, 1, 1, 32'h300, 1, 32'h200, 0, 0);
        chk("exc_priority", PCResult, 32'h80);
        drive(0, 0, 1, 32'h303, 0, 32'h0, 0, 0);
        chk("branch_align", PCResult, 32'h300);

        // Three-cycle stall with a jump in the middle cycle
        drive(0, 0, 0, 32'h0, 1, 32'h100, 0, 0);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("stall1_pc", PCResult, 32'h100);
        drive(1, 0, 0, 32'h0, 1, 32'h200, 0, 0);
        chk("stall2_pc", PCResult, 32'h100);
        chk("stall2_pending", {31'h0, RedirectPending}, 32'h1);
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("stall3_pc", PCResult, 32'h100);
        chk("stall3_pending", {31'h0, RedirectPending}, 32'h1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("unstall_pc", PCResult, 32'h200);
        chk("unstall_pending", {31'h0, RedirectPending}, 32'h0);

        // Stalled jump then branch, and the reverse order
        drive(1, 0, 0, 32'h0, 1, 32'h200, 0, 0);
        drive(1, 0, 1, 32'h300, 0, 32'h0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("jmp_then_br", PCResult, 32'h300);
        drive(1, 0, 1, 32'h300, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 32'h0, 1, 32'h200, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("br_then_jmp", PCResult, 32'h300);

        // Asynchronous reset mid-run, also discarding a pending redirect
        drive(0, 0, 0, 32'h0, 1, 32'h40, 0, 0);
        chk("pre_reset_pc", PCResult, 32'h40);
        set_in(1, 0, 0, 32'h0, 1, 32'h500, 0, 0);
        #2 Reset = 1'b0;
        #1 chk("async_reset_pc", PCResult, 32'h0);
        chk("async_reset_pending", {31'h0, RedirectPending}, 32'h0);
        set_in(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 chk("release_pc0", PCResult, 32'h0);
        @(negedge Clk);
        chk("release_pc4", PCResult, 32'h4);
        @(negedge Clk);
        chk("release_pc8", PCResult, 32'h8);

        if (RasEn) begin
            drive(0, 0, 0, 32'h0, 1, 32'h10, 0, 0);
            for (int k = 1; k <= 5; k++) begin
                drive(0, 0, 0, 32'h0, 1, (k == 5) ? 32'h100 : 32'((k + 1) * 16), 1, 0);
            end
            for (int k = 0; k < 4; k++) begin
                drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
                chk("ras_ret", PCResult, 32'h54 - 32'(k * 16));
            end
            chk("ras_empty_after4", {31'h0, RasEmpty}, 32'h1);
            drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
            chk("ras_ret_empty", PCResult, 32'h28);
        end else begin
            // Call/return requests have no effect without the stack
            drive(0, 0, 0, 32'h0, 0, 32'h0, 1, 1);
            chk("noras_call", PCResult, 32'hC);
            drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
            chk("noras_ret", PCResult, 32'h10);
            chk("noras_empty", {31'h0, RasEmpty}, 32'h1);
        end

        // Randomised phase, checked by the per-cycle model comparison
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                set_in(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
                #2 Reset = 1'b0;
                @(negedge Clk);
                #2 Reset = 1'b1;
            end
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 5) == 0, $urandom,
                   $urandom_range(0, 5) == 0, $urandom,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            @(negedge Clk);
        end

        set_in(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge Clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
